// File: rtl/alu16b_pkg.sv
// Shared definitions for the alu16b sequencer: opcodes, ALU select codes and FSM states.
package alu16b_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_CLRF = 3'b101;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_MUL = 2'b10;
  localparam logic [1:0] SEL_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ALU select for an opcode; non-ALU opcodes park the select on add.
  function automatic logic [1:0] op_to_sel(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_ADD:  sel = SEL_ADD;
      OP_SUB:  sel = SEL_SUB;
      OP_MUL:  sel = SEL_MUL;
      OP_DIV:  sel = SEL_DIV;
      default: sel = SEL_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu16b_seq.sv
// Command/response sequencer that drives an external combinational alu16b from an
// accumulator and operand register, one command at a time.
module alu16b_seq
  import alu16b_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_ov,
  output logic         rsp_err,
  output logic         ov_sticky,
  output logic [W-1:0] alu_ina,
  output logic [W-1:0] alu_inb,
  output logic [1:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  input  logic         alu_ov
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_accept;

  logic [2:0]     r_op;
  logic [W-1:0]   r_opnd;
  logic [W-1:0]   r_acc;
  logic           r_cmd_ready;
  logic           r_rsp_valid;
  logic [W-1:0]   r_rsp_data;
  logic           r_rsp_ov;
  logic           r_rsp_err;
  logic           r_ov_sticky;
  logic [W-1:0]   r_alu_ina;
  logic [W-1:0]   r_alu_inb;
  logic [1:0]     r_alu_sel;

  logic [W-1:0]   w_acc_nxt;
  logic           w_ov_nxt;
  logic           w_err_nxt;
  logic           w_clr_sticky;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and command handshake
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Result of the command in EXEC, applied on the edge that leaves EXEC
  always_comb begin
    w_acc_nxt    = r_acc;
    w_ov_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
    w_clr_sticky = 1'b0;
    case (r_op)
      OP_LOAD: begin
        w_acc_nxt = r_opnd;
      end
      OP_ADD, OP_SUB, OP_MUL: begin
        w_acc_nxt = alu_out;
        w_ov_nxt  = alu_ov;
      end
      OP_DIV: begin
        // Divide by zero keeps the accumulator and suppresses the ALU flag.
        if (r_opnd == {W{1'b0}}) begin
          w_err_nxt = 1'b1;
        end else begin
          w_acc_nxt = alu_out;
          w_ov_nxt  = alu_ov;
        end
      end
      OP_CLRF: begin
        w_clr_sticky = 1'b1;
      end
      default: begin
        w_err_nxt = 1'b1;
      end
    endcase
  end

  // Datapath, ALU drive and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= 3'b000;
      r_opnd      <= {W{1'b0}};
      r_acc       <= {W{1'b0}};
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {W{1'b0}};
      r_rsp_ov    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_ov_sticky <= 1'b0;
      r_alu_ina   <= {W{1'b0}};
      r_alu_inb   <= {W{1'b0}};
      r_alu_sel   <= SEL_ADD;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_op      <= cmd_op;
        r_opnd    <= cmd_data;
        r_alu_ina <= r_acc;
        r_alu_inb <= cmd_data;
        r_alu_sel <= op_to_sel(cmd_op);
      end
      if (r_state == ST_EXEC) begin
        r_acc       <= w_acc_nxt;
        r_rsp_data  <= w_acc_nxt;
        r_rsp_ov    <= w_ov_nxt;
        r_rsp_err   <= w_err_nxt;
        r_rsp_valid <= 1'b1;
        r_ov_sticky <= w_clr_sticky ? 1'b0 : (r_ov_sticky | w_ov_nxt);
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_ov    = r_rsp_ov;
  assign rsp_err   = r_rsp_err;
  assign ov_sticky = r_ov_sticky;
  assign alu_ina   = r_alu_ina;
  assign alu_inb   = r_alu_inb;
  assign alu_sel   = r_alu_sel;

endmodule

// File: tb/tb_alu16b_seq.sv
// Directed bench for alu16b_seq with a behavioural alu16b on the alu_* ports.
module tb_alu16b_seq;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_ov;
  logic        rsp_err;
  logic        ov_sticky;
  logic [15:0] alu_ina;
  logic [15:0] alu_inb;
  logic [1:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_ov;

  int n_checks = 0;
  int n_errors = 0;

  alu16b_seq #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ov    (rsp_ov),
    .rsp_err   (rsp_err),
    .ov_sticky (ov_sticky),
    .alu_ina   (alu_ina),
    .alu_inb   (alu_inb),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_ov    (alu_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu16b: add carry-out, signed sub overflow, mul upper-half, div-by-zero flag.
  always_comb begin
    logic [16:0] sum;
    logic [31:0] prod;
    sum     = 17'd0;
    prod    = 32'd0;
    alu_out = 16'd0;
    alu_ov  = 1'b0;
    case (alu_sel)
      2'b00: begin
        sum     = {1'b0, alu_ina} + {1'b0, alu_inb};
        alu_out = sum[15:0];
        alu_ov  = sum[16];
      end
      2'b01: begin
        alu_out = alu_ina - alu_inb;
        alu_ov  = (alu_ina[15] != alu_inb[15]) && (alu_out[15] != alu_ina[15]);
      end
      2'b10: begin
        prod    = {16'd0, alu_ina} * {16'd0, alu_inb};
        alu_out = prod[15:0];
        alu_ov  = |prod[31:16];
      end
      default: begin
        if (alu_inb == 16'd0) begin
          alu_out = 16'hFFFF;
          alu_ov  = 1'b1;
        end else begin
          alu_out = alu_ina / alu_inb;
          alu_ov  = 1'b0;
        end
      end
    endcase
  end

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
    end
  endtask

  // Waits for cmd_ready, issues one command, checks the EXEC-cycle ALU drive and latency.
  task automatic start_cmd(input string tag, input logic [2:0] op, input logic [15:0] data,
                           input logic [15:0] exp_ina, input logic [1:0] exp_sel);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " cmd_ready"}, 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 16'hDEAD;
    check_eq({tag, " exec rsp_valid"}, 16'(rsp_valid), 16'd0);
    check_eq({tag, " exec alu_ina"}, alu_ina, exp_ina);
    check_eq({tag, " exec alu_inb"}, alu_inb, data);
    check_eq({tag, " exec alu_sel"}, 16'(alu_sel), 16'(exp_sel));
    @(negedge clk);
    check_eq({tag, " rsp_valid"}, 16'(rsp_valid), 16'd1);
  endtask

  task automatic check_rsp(input string tag, input logic [15:0] exp_data, input logic exp_ov,
                           input logic exp_err, input logic exp_sticky);
    check_eq({tag, " rsp_data"}, rsp_data, exp_data);
    check_eq({tag, " rsp_ov"}, 16'(rsp_ov), 16'(exp_ov));
    check_eq({tag, " rsp_err"}, 16'(rsp_err), 16'(exp_err));
    check_eq({tag, " ov_sticky"}, 16'(ov_sticky), 16'(exp_sticky));
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, " rsp_valid drop"}, 16'(rsp_valid), 16'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [15:0] data,
                         input logic [15:0] exp_ina, input logic [1:0] exp_sel,
                         input logic [15:0] exp_data, input logic exp_ov,
                         input logic exp_err, input logic exp_sticky);
    start_cmd(tag, op, data, exp_ina, exp_sel);
    check_rsp(tag, exp_data, exp_ov, exp_err, exp_sticky);
    finish_rsp(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = 16'h0000;
    rsp_ready = 1'b0;
    #1;
    check_eq("reset cmd_ready", 16'(cmd_ready), 16'd0);
    check_eq("reset rsp_valid", 16'(rsp_valid), 16'd0);
    check_eq("reset rsp_data", rsp_data, 16'h0000);
    check_eq("reset ov_sticky", 16'(ov_sticky), 16'd0);
    check_eq("reset alu_sel", 16'(alu_sel), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("release cmd_ready", 16'(cmd_ready), 16'd0);
    @(negedge clk);
    check_eq("first clk cmd_ready", 16'(cmd_ready), 16'd1);

    run_cmd("load_ffff", 3'b000, 16'hFFFF, 16'h0000, 2'b00, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_cmd("add_1",     3'b001, 16'h0001, 16'hFFFF, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_cmd("load_5",    3'b000, 16'h0005, 16'h0000, 2'b00, 16'h0005, 1'b0, 1'b0, 1'b1);
    run_cmd("sub_3",     3'b010, 16'h0003, 16'h0005, 2'b01, 16'h0002, 1'b0, 1'b0, 1'b1);
    run_cmd("clrf",      3'b101, 16'h0000, 16'h0002, 2'b00, 16'h0002, 1'b0, 1'b0, 1'b0);
    run_cmd("load_100",  3'b000, 16'h0100, 16'h0002, 2'b00, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_cmd("mul_100",   3'b011, 16'h0100, 16'h0100, 2'b10, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_cmd("load_7",    3'b000, 16'h0007, 16'h0000, 2'b00, 16'h0007, 1'b0, 1'b0, 1'b1);
    run_cmd("mul_3",     3'b011, 16'h0003, 16'h0007, 2'b10, 16'h0015, 1'b0, 1'b0, 1'b1);
    run_cmd("load_10",   3'b000, 16'h0010, 16'h0015, 2'b00, 16'h0010, 1'b0, 1'b0, 1'b1);
    run_cmd("div_0",     3'b100, 16'h0000, 16'h0010, 2'b11, 16'h0010, 1'b0, 1'b1, 1'b1);
    run_cmd("op_111",    3'b111, 16'h0055, 16'h0010, 2'b00, 16'h0010, 1'b0, 1'b1, 1'b1);
    run_cmd("div_2",     3'b100, 16'h0002, 16'h0010, 2'b11, 16'h0008, 1'b0, 1'b0, 1'b1);
    run_cmd("load_8000", 3'b000, 16'h8000, 16'h0008, 2'b00, 16'h8000, 1'b0, 1'b0, 1'b1);
    run_cmd("sub_ovf",   3'b010, 16'h0001, 16'h8000, 2'b01, 16'h7FFF, 1'b1, 1'b0, 1'b1);

    // Backpressure: response held, new commands must be ignored.
    start_cmd("load_aa", 3'b000, 16'h00AA, 16'h7FFF, 2'b00);
    check_rsp("load_aa", 16'h00AA, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'b000;
      cmd_data  = 16'h1234;
      @(negedge clk);
      check_eq("hold rsp_valid", 16'(rsp_valid), 16'd1);
      check_eq("hold rsp_data", rsp_data, 16'h00AA);
      check_eq("hold cmd_ready", 16'(cmd_ready), 16'd0);
    end
    cmd_valid = 1'b0;
    finish_rsp("load_aa");
    run_cmd("add_0",     3'b001, 16'h0000, 16'h00AA, 2'b00, 16'h00AA, 1'b0, 1'b0, 1'b1);
    run_cmd("load_42",   3'b000, 16'h0042, 16'h00AA, 2'b00, 16'h0042, 1'b0, 1'b0, 1'b1);

    // Reset while the ADD is in EXEC: command aborted, everything back to zero.
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 16'h0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("abort in exec", 16'(alu_inb), 16'h0001);
    rst_n = 1'b0;
    #1;
    check_eq("abort rsp_valid", 16'(rsp_valid), 16'd0);
    check_eq("abort rsp_data", rsp_data, 16'h0000);
    check_eq("abort alu_ina", alu_ina, 16'h0000);
    check_eq("abort ov_sticky", 16'(ov_sticky), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort no rsp", 16'(rsp_valid), 16'd0);
    run_cmd("post_rst_add", 3'b001, 16'h0003, 16'h0000, 2'b00, 16'h0003, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
